// File: rtl/pdm_pkg.sv
// Shared parameters and arithmetic helpers for the PCM-to-PDM sigma-delta transmit path.
package pdm_pkg;

  localparam int OSR      = 64;
  localparam int L        = $clog2(OSR);
  localparam int DATA_W   = 16;
  localparam int ACC_W    = 24;
  localparam int CLIP     = 24576;
  localparam int FS       = 2 ** (DATA_W - 1);

  // Loop sums need two guard bits so saturation sees the true value before clamping.
  localparam int SUM_W    = ACC_W + 2;
  localparam int DELTA_W  = DATA_W + 1;
  localparam int INTERP_W = DATA_W + L + 1;

  localparam logic signed [ACC_W-1:0]  ACC_MAX = ACC_W'(2 ** (ACC_W - 1) - 1);
  localparam logic signed [ACC_W-1:0]  ACC_MIN = -ACC_MAX;
  localparam logic signed [DATA_W-1:0] PCM_MAX = DATA_W'(CLIP - 1);
  localparam logic signed [DATA_W-1:0] PCM_MIN = DATA_W'(-CLIP);

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
    if (v > SUM_W'(ACC_MAX))      return ACC_MAX;
    else if (v < SUM_W'(ACC_MIN)) return ACC_MIN;
    else                          return ACC_W'(v);
  endfunction

  function automatic logic signed [DATA_W-1:0] clamp_pcm(input logic signed [DATA_W-1:0] v);
    if (v > PCM_MAX)      return PCM_MAX;
    else if (v < PCM_MIN) return PCM_MIN;
    else                  return v;
  endfunction

endpackage

// File: rtl/pdm_sd2_core.sv
// Second-order sigma-delta loop: interpolated sample x in, one PDM bit per clock out.
module pdm_sd2_core
  import pdm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] x_i,
  output logic                     pdm_o
);

  logic signed [ACC_W-1:0] i1_q, i1_d;
  logic signed [ACC_W-1:0] i2_q, i2_d;
  logic signed [SUM_W-1:0] fb;
  logic                    y;
  logic                    pdm_q;

  // Both integrators update from the old i1, so i2 lags i1 by one cycle.
  always_comb begin
    y    = ~i2_q[ACC_W-1];
    fb   = y ? SUM_W'(FS) : -SUM_W'(FS);
    i1_d = sat_acc(SUM_W'(i1_q) + SUM_W'(x_i) - fb);
    i2_d = sat_acc(SUM_W'(i2_q) + SUM_W'(i1_q) - fb);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q  <= '0;
      i2_q  <= '0;
      pdm_q <= 1'b0;
    end else begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      pdm_q <= y;
    end
  end

  assign pdm_o = pdm_q;

endmodule

// File: rtl/pdm_sd2_modulator.sv
// PCM-to-PDM transmitter: one-entry input buffer, frame counter, linear interpolator
// feeding the second-order sigma-delta core.
module pdm_sd2_modulator
  import pdm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] pcm_in,
  input  logic                     pcm_valid,
  output logic                     pcm_ready,
  output logic                     pdm_out,
  output logic                     underrun
);

  logic        [L-1:0]          cnt_q, cnt_d;
  logic signed [DATA_W-1:0]     buf_q, buf_d;
  logic                         buf_full_q, buf_full_d;
  logic signed [DATA_W-1:0]     cur_q, cur_d;
  logic signed [DATA_W-1:0]     prev_q, prev_d;
  logic signed [INTERP_W-1:0]   acc_q, acc_d;
  logic signed [DELTA_W-1:0]    delta_q, delta_d;
  logic                         underrun_q, underrun_d;
  logic signed [DATA_W-1:0]     x;
  logic                         boundary, load, accept, pdm_bit;

  assign boundary = (cnt_q == L'(OSR - 1));
  assign load     = (cnt_q == '0);
  assign accept   = pcm_valid & ~buf_full_q;

  // NOTE: every _d gets a default before the conditionals so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d      = cnt_q + L'(1);
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    cur_d      = cur_q;
    prev_d     = prev_q;
    underrun_d = boundary & ~buf_full_q;

    if (boundary) begin
      prev_d = cur_q;
      if (buf_full_q) begin
        cur_d      = buf_q;
        buf_full_d = 1'b0;
      end
    end

    // Only possible with an empty buffer, so it never collides with the drain above.
    if (accept) begin
      buf_d      = clamp_pcm(pcm_in);
      buf_full_d = 1'b1;
    end

    // Ramp restarts one cycle after the boundary from prev towards cur.
    if (load) begin
      acc_d   = INTERP_W'(prev_q) <<< L;
      delta_d = DELTA_W'(cur_q) - DELTA_W'(prev_q);
    end else begin
      acc_d   = acc_q + INTERP_W'(delta_q);
      delta_d = delta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      cur_q      <= '0;
      prev_q     <= '0;
      acc_q      <= '0;
      delta_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      cur_q      <= cur_d;
      prev_q     <= prev_d;
      acc_q      <= acc_d;
      delta_q    <= delta_d;
      underrun_q <= underrun_d;
    end
  end

  assign x = DATA_W'(acc_q >>> L);

  pdm_sd2_core u_core (
    .clk   (clk),
    .rst   (rst),
    .x_i   (x),
    .pdm_o (pdm_bit)
  );

  // Outputs are forced low while reset is asserted, not just after the reset edge.
  assign pcm_ready = ~buf_full_q & ~rst;
  assign pdm_out   = pdm_bit & ~rst;
  assign underrun  = underrun_q & ~rst;

endmodule

// File: tb/tb_pdm_sd2_modulator.sv
// Directed self-checking bench for pdm_sd2_modulator: handshake, interpolation ramp,
// bit density, clamping, underrun and mid-frame reset.
module tb_pdm_sd2_modulator;
  import pdm_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [DATA_W-1:0] pcm_in;
  logic                     pcm_valid;
  logic                     pcm_ready;
  logic                     pdm_out;
  logic                     underrun;

  int checks = 0;
  int errors = 0;
  int pos, cyc, ones, urs, accepts;
  bit range_ok;

  pdm_sd2_modulator dut (
    .clk       (clk),
    .rst       (rst),
    .pcm_in    (pcm_in),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .pdm_out   (pdm_out),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns exp when obs is within tol, otherwise obs, so check() reports the real value.
  function automatic longint near(input longint obs, input longint exp, input longint tol);
    return (obs >= exp - tol && obs <= exp + tol) ? exp : obs;
  endfunction

  // Integrators must never reach -2^(ACC_W-1); saturation is symmetric.
  always @(negedge clk) begin
    if (!rst) begin
      if (dut.u_core.i1_q == -(2 ** (ACC_W - 1)) || dut.u_core.i2_q == -(2 ** (ACC_W - 1)))
        range_ok = 1'b0;
    end
  end

  task automatic step();
    if (pcm_valid && pcm_ready) accepts++;
    @(negedge clk);
    pos = (pos + 1) % OSR;
    cyc++;
    if (pdm_out)  ones++;
    if (underrun) urs++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    pcm_valid = 1'b0;
    pcm_in    = '0;
    @(negedge clk);
    check("rst_ready", pcm_ready, 0);
    check("rst_pdm", pdm_out, 0);
    check("rst_underrun", underrun, 0);
    rst = 1'b0;
    pos = 0;
    cyc = 0;
    #1;
    check("ready_after_rst", pcm_ready, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Zero input: limit cycle 1,0,0,1 gives exactly half ones, never an underrun.
    do_reset();
    pcm_valid = 1'b1;
    ones = 0; urs = 0;
    repeat (1024) step();
    check("zero_ones", near(ones, 512, 2), 512);
    check("zero_underrun", urs, 0);

    // Handshake with valid held high: one accept per frame, ready back one clk after boundary.
    do_reset();
    pcm_in = 16'sd1000; pcm_valid = 1'b1;
    accepts = 0;
    for (int i = 0; i < 4 * OSR; i++) begin
      step();
      if (pos == 1)  check("ready_after_accept", pcm_ready, 0);
      if (pos == 63) check("ready_before_bnd", pcm_ready, 0);
      if (pos == 0)  check("ready_after_bnd", pcm_ready, 1);
    end
    check("accepts_per_frame", accepts, 4);

    // Interpolator ramp 0 -> 8192 (delta 8192), then hold, then floor on a -1 step.
    do_reset();
    pcm_in = 16'sd8192; pcm_valid = 1'b1;
    step();
    pcm_valid = 1'b0;
    run_to(65);  check("ramp_k0", dut.x, 0);
    run_to(97);  check("ramp_k32", dut.x, 4096);
    run_to(127); check("ramp_k62", dut.x, 7936);
    run_to(128); check("hold_underrun", underrun, 1);
    run_to(129); check("hold_x", dut.x, 8192);
    run_to(133);
    pcm_in = 16'sd8191; pcm_valid = 1'b1;
    step();
    pcm_valid = 1'b0;
    run_to(192); check("refill_no_underrun", underrun, 0);
    run_to(193); check("floor_k0", dut.x, 8192);
    run_to(194); check("floor_k1", dut.x, 8191);
    // Valid arriving in the boundary cycle with an empty buffer: stored, yet underrun still pulses.
    run_to(255);
    pcm_in = 16'sd0; pcm_valid = 1'b1;
    step();
    pcm_valid = 1'b0;
    check("bnd_valid_underrun", underrun, 1);
    check("bnd_valid_stored", pcm_ready, 0);
    run_to(320); check("bnd_valid_next", underrun, 0);

    // Positive full-scale input clamps to 24575; density (24575+32768)/65536.
    do_reset();
    range_ok = 1'b1;
    pcm_in = 16'sd32767; pcm_valid = 1'b1;
    step();
    check("clamp_pos", dut.buf_q, 24575);
    run_to(192);
    ones = 0;
    repeat (4096) step();
    check("density_pos_clip", near(ones, 3584, 41), 3584);
    check("integrators_in_range", range_ok, 1);

    // Negative full-scale input clamps to -24576; density 8192/65536.
    do_reset();
    range_ok = 1'b1;
    pcm_in = -16'sd32768; pcm_valid = 1'b1;
    step();
    check("clamp_neg", dut.buf_q, -24576);
    run_to(192);
    ones = 0;
    repeat (4096) step();
    check("density_neg_clip", near(ones, 512, 41), 512);
    check("integrators_in_range_neg", range_ok, 1);

    // -8192 constant: density 0.375.
    do_reset();
    pcm_in = -16'sd8192; pcm_valid = 1'b1;
    run_to(192);
    ones = 0;
    repeat (1024) step();
    check("density_m8192", near(ones, 384, 6), 384);

    // Feed 8192 then stop: underrun every boundary, density held; resume clears it.
    do_reset();
    pcm_in = 16'sd8192; pcm_valid = 1'b1;
    run_to(3 * OSR + 10);
    pcm_valid = 1'b0;
    run_to(320);
    ones = 0; urs = 0;
    repeat (1024) step();
    check("starved_density", near(ones, 640, 6), 640);
    check("starved_underruns", urs, 16);
    run_to(1349);
    pcm_valid = 1'b1;
    urs = 0;
    run_to(1600);
    check("resume_underruns", urs, 0);

    // One-cycle reset at cnt=30 while the buffer is full.
    do_reset();
    pcm_in = 16'sd500; pcm_valid = 1'b1;
    step();
    pcm_valid = 1'b0;
    run_to(30);
    check("buf_full_at_30", pcm_ready, 0);
    rst = 1'b1;
    #1;
    check("midrst_ready_low", pcm_ready, 0);
    check("midrst_pdm_low", pdm_out, 0);
    @(negedge clk);
    rst = 1'b0;
    pos = 0; cyc = 0;
    #1;
    check("midrst_ready", pcm_ready, 1);
    check("midrst_pdm", pdm_out, 0);
    check("midrst_cnt", dut.cnt_q, 0);
    step();
    check("midrst_first_bit", pdm_out, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
